// File: rtl/song_sequencer.sv
// Song playback engine: walks one song's slots through a registered library
// read port and drives timed note/octave codes to the tone generator.
module song_sequencer #(
    parameter int                NUM_SONGS      = 4,
    parameter int                NOTES          = 56,
    parameter int                NOTE_W         = 4,
    parameter int                DUR_W          = 4,
    parameter int                OCT_W          = 2,
    parameter logic [NOTE_W-1:0] PAD_CODE       = 4'hF,
    parameter int                TICKS_PER_UNIT = 5_000_000,
    localparam int               SW             = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1,
    localparam int               IW             = (NOTES > 1) ? $clog2(NOTES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW-1:0]     song_sel,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop,
    output logic [SW-1:0]     lib_song,
    output logic [IW-1:0]     lib_idx,
    input  logic [NOTE_W-1:0] lib_note,
    input  logic [DUR_W-1:0]  lib_dur,
    input  logic [OCT_W-1:0]  lib_oct,
    output logic [NOTE_W-1:0] note,
    output logic [OCT_W-1:0]  octave,
    output logic              note_valid,
    output logic              playing,
    output logic              done,
    output logic [IW-1:0]     cur_idx
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] PLAY   = 3'd3;
    localparam logic [2:0] PAUSED = 3'd4;

    // One spare bit so lib_dur * TICKS_PER_UNIT can never wrap.
    localparam int            CW    = DUR_W + $clog2(TICKS_PER_UNIT) + 1;
    localparam logic [CW-1:0] TICKS = CW'(TICKS_PER_UNIT);
    localparam logic [IW-1:0] LAST  = IW'(NOTES - 1);

    logic [2:0]    state, nxt_state;
    logic [2:0]    saved, nxt_saved;
    logic [CW-1:0] cnt, nxt_cnt;
    logic [IW-1:0] nxt_idx;
    logic [SW-1:0] nxt_song;
    logic          nxt_done;
    logic          load_note;

    logic [2:0]    adv_state;
    logic [IW-1:0] adv_idx;
    logic          adv_done;
    logic          skip;

    assign skip = (lib_note == PAD_CODE) || (lib_dur == '0);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        adv_state = FETCH;
        adv_idx   = '0;
        adv_done  = 1'b0;
        if (lib_idx != LAST) begin
            adv_idx = lib_idx + 1'b1;
        end else if (!loop) begin
            adv_state = IDLE;
            adv_idx   = lib_idx;
            adv_done  = 1'b1;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_saved = saved;
        nxt_cnt   = cnt;
        nxt_idx   = lib_idx;
        nxt_song  = lib_song;
        nxt_done  = 1'b0;
        load_note = 1'b0;

        case (state)
            FETCH:  nxt_state = DECODE;
            DECODE: begin
                if (skip) begin
                    nxt_state = adv_state;
                    nxt_idx   = adv_idx;
                    nxt_done  = adv_done;
                end else begin
                    load_note = 1'b1;
                    nxt_cnt   = CW'(lib_dur) * TICKS - 1'b1;
                    nxt_state = PLAY;
                end
            end
            PLAY: begin
                if (cnt == '0) begin
                    nxt_state = adv_state;
                    nxt_idx   = adv_idx;
                    nxt_done  = adv_done;
                end else begin
                    nxt_cnt = cnt - 1'b1;
                end
            end
            PAUSED: if (!pause) nxt_state = saved;
            default: nxt_state = IDLE;
        endcase

        // The current cycle completes normally; the machine freezes from the next one.
        if (pause && (state == FETCH || state == DECODE || state == PLAY) && nxt_state != IDLE) begin
            nxt_saved = nxt_state;
            nxt_state = PAUSED;
        end

        if (start) begin
            nxt_state = FETCH;
            nxt_idx   = '0;
            nxt_song  = song_sel;
            nxt_cnt   = '0;
            nxt_done  = 1'b0;
            load_note = 1'b0;
        end

        if (stop) begin
            nxt_state = IDLE;
            nxt_done  = 1'b0;
            load_note = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            saved      <= IDLE;
            cnt        <= '0;
            lib_idx    <= '0;
            lib_song   <= '0;
            note       <= '0;
            octave     <= '0;
            note_valid <= 1'b0;
            playing    <= 1'b0;
            done       <= 1'b0;
            cur_idx    <= '0;
        end else begin
            state      <= nxt_state;
            saved      <= nxt_saved;
            cnt        <= nxt_cnt;
            lib_idx    <= nxt_idx;
            lib_song   <= nxt_song;
            done       <= nxt_done;
            note_valid <= (nxt_state == PLAY);
            playing    <= (nxt_state != IDLE);
            if (load_note) begin
                note    <= lib_note;
                octave  <= lib_oct;
                cur_idx <= lib_idx;
            end else if (stop) begin
                note <= '0;
            end
        end
    end

endmodule
